time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable synchronized samples needed to accept a button level.
REQ-002 Parameter BLINK_CYCLES, default 50000000, is the number of cycles per blink half-period.
REQ-003 One clock, asynchronous active-low reset; ports follow.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 btn_mode  in  1  raw asynchronous button, active-high; enters, advances and leaves edit mode.
REQ-007 btn_inc  in  1  raw asynchronous button, active-high; adds one unit of the selected field.
REQ-008 btn_dec  in  1  raw asynchronous button, active-high; subtracts one unit of the selected field.
REQ-009 counter_in  in  64  live Unix-seconds value from the time counter.
REQ-010 go  out  1  run enable to the time counter; 1 means counting.
REQ-011 load_n  out  1  active-low one-cycle load strobe to the time counter.
REQ-012 load_value  out  64  value to load; always equals the shadow register.
REQ-013 edit_field  out  2  selected field: 0 = sec, 1 = min, 2 = hour, 3 = day; 0 in RUN.
REQ-014 blink  out  1  display blink phase; 0 outside edit states.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter that accepts a new level only after DEBOUNCE_CYCLES equal consecutive samples.
REQ-016 Each debounced 0->1 transition SHALL produce a one-cycle press pulse; holding a button SHALL NOT auto-repeat, and release SHALL produce no pulse.
REQ-017 FSM states SHALL be RUN, E_SEC, E_MIN, E_HOUR, E_DAY, COMMIT.
REQ-018 RUN + mode pulse: shadow <= counter_in, go <= 0 on the same edge, next state E_SEC.
REQ-019 A mode pulse SHALL advance E_SEC->E_MIN->E_HOUR->E_DAY->COMMIT.
REQ-020 COMMIT SHALL last exactly one cycle with load_n = 0, go = 0, then return to RUN with load_n = 1, go = 1.
REQ-021 Field units SHALL be sec = 1, min = 60, hour = 3600, day = 86400, applied to the 64-bit shadow.
REQ-022 An inc pulse in an edit state SHALL add the unit, saturating at 2^64-1.
REQ-023 A dec pulse in an edit state SHALL subtract the unit, saturating at 0.
REQ-024 The shadow update SHALL be visible on load_value the cycle after the pulse.
REQ-025 inc and dec pulses in the same cycle SHALL both be ignored.
REQ-026 If mode and inc/dec pulse in the same cycle, mode SHALL win and inc/dec is dropped.
REQ-027 inc/dec pulses in RUN or COMMIT SHALL be ignored; the shadow is unchanged.
REQ-028 blink SHALL toggle every BLINK_CYCLES while in an edit state, with its counter cleared and blink = 1 on entry to E_SEC.
REQ-029 edit_field SHALL be registered and change on the same edge as the state.

Reset
REQ-030 While reset_n = 0: state RUN, go = 1, load_n = 1, shadow = 0, edit_field = 0, blink = 0, synchronizers and debounce counters cleared, debounced levels 0.
REQ-031 Reset asserted mid-edit SHALL abandon the edit with no load strobe; counting resumes (go = 1) at deassertion.
REQ-032 Reset deassertion SHALL be recognized on the next rising clk edge; no pulses are generated from buttons already held at deassertion until they are released and pressed again.

Verification (DEBOUNCE_CYCLES = 4, BLINK_CYCLES = 8)
REQ-033 A 2-cycle btn_mode glitch in RUN -> no state change, go stays 1.
REQ-034 counter_in = 1000, press mode -> go = 0, load_value = 1000, edit_field = 0; press inc twice -> 1002; press mode -> edit_field = 1; press dec -> 942.
REQ-035 Shadow = 30 in E_MIN, press dec -> 0; in E_DAY with shadow = 2^64-100, press inc -> 2^64-1.
REQ-036 From E_DAY press mode -> exactly one cycle with load_n = 0 and load_value equal to the shadow, next cycle go = 1 and edit_field = 0.
REQ-037 inc and dec pulses in the same cycle -> shadow unchanged; mode and inc pulses in the same cycle -> field advances and shadow unchanged.
REQ-038 In E_HOUR, assert reset_n = 0 for 3 cycles -> no load_n pulse; after release go = 1, edit_field = 0, blink = 0.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Time-set controller: debounced mode/inc/dec buttons drive an edit FSM.
// The FSM adjusts a 64-bit shadow of the Unix-seconds counter and loads it back on commit.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic [63:0] counter_in,
  output logic        go,
  output logic        load_n,
  output logic [63:0] load_value,
  output logic [1:0]  edit_field,
  output logic        blink
);

  localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] E_SEC  = 3'd1;
  localparam logic [2:0] E_MIN  = 3'd2;
  localparam logic [2:0] E_HOUR = 3'd3;
  localparam logic [2:0] E_DAY  = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {btn_dec, btn_inc, btn_mode};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic          s1_q, s2_q, last_q, deb_q, armed_q, press_q;
      logic [RW-1:0] run_q, run_d;
      logic          stable;

      // run_q counts consecutive equal synchronized samples, saturating at DEBOUNCE_CYCLES.
      always_comb begin
        if (run_q == '0 || s2_q != last_q) run_d = RW'(1);
        else if (run_q == RW'(DEBOUNCE_CYCLES)) run_d = run_q;
        else run_d = run_q + RW'(1);
      end

      assign stable = (run_d == RW'(DEBOUNCE_CYCLES));

      // A press is only honoured once the button has been seen stably released,
      // so a button held through reset produces no pulse.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          last_q  <= 1'b0;
          deb_q   <= 1'b0;
          armed_q <= 1'b0;
          press_q <= 1'b0;
          run_q   <= '0;
        end else begin
          s1_q    <= btn_raw[gi];
          s2_q    <= s1_q;
          last_q  <= s2_q;
          run_q   <= run_d;
          if (stable) deb_q <= s2_q;
          if (stable && !s2_q) armed_q <= 1'b1;
          press_q <= stable && s2_q && !deb_q && armed_q;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic          mode_p, inc_p, dec_p;
  logic [2:0]    state_q, state_d;
  logic [63:0]   shadow_q, shadow_d;
  logic          go_q, go_d, load_n_q, load_n_d, blink_q, blink_d;
  logic [1:0]    field_q, field_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [63:0]   unit;
  logic [64:0]   sum;

  assign mode_p = press[0];
  assign inc_p  = press[1] & ~press[2];
  assign dec_p  = press[2] & ~press[1];

  always_comb begin
    case (field_q)
      2'd0:    unit = 64'd1;
      2'd1:    unit = 64'd60;
      2'd2:    unit = 64'd3600;
      default: unit = 64'd86400;
    endcase
  end

  assign sum = {1'b0, shadow_q} + {1'b0, unit};

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    go_d     = go_q;
    load_n_d = load_n_q;
    field_d  = field_q;
    blink_d  = blink_q;
    bcnt_d   = bcnt_q;
    case (state_q)
      RUN: begin
        go_d     = 1'b1;
        load_n_d = 1'b1;
        if (mode_p) begin
          shadow_d = counter_in;
          go_d     = 1'b0;
          state_d  = E_SEC;
          field_d  = 2'd0;
          blink_d  = 1'b1;
          bcnt_d   = '0;
        end
      end
      E_SEC, E_MIN, E_HOUR, E_DAY: begin
        if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
          bcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d  = bcnt_q + BW'(1);
        end
        // Mode has priority; a simultaneous inc/dec is dropped.
        if (mode_p) begin
          if (state_q == E_DAY) begin
            state_d  = COMMIT;
            load_n_d = 1'b0;
            field_d  = 2'd0;
            blink_d  = 1'b0;
            bcnt_d   = '0;
          end else begin
            state_d  = state_q + 3'd1;
            field_d  = field_q + 2'd1;
          end
        end else if (inc_p) begin
          shadow_d = sum[64] ? '1 : sum[63:0];
        end else if (dec_p) begin
          shadow_d = (shadow_q < unit) ? '0 : shadow_q - unit;
        end
      end
      COMMIT: begin
        state_d  = RUN;
        load_n_d = 1'b1;
        go_d     = 1'b1;
      end
      default: begin
        state_d  = RUN;
        go_d     = 1'b1;
        load_n_d = 1'b1;
        field_d  = 2'd0;
        blink_d  = 1'b0;
        bcnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      shadow_q <= '0;
      go_q     <= 1'b1;
      load_n_q <= 1'b1;
      field_q  <= 2'd0;
      blink_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      go_q     <= go_d;
      load_n_q <= load_n_d;
      field_q  <= field_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign go         = go_q;
  assign load_n     = load_n_q;
  assign load_value = shadow_q;
  assign edit_field = field_q;
  assign blink      = blink_q;

endmodule
